// File: rtl/sha256_round_core_if.sv
// Handshake bundle between the SHA-256 round core and its driver / schedule datapath.
// With SHA_HOLD_EN defined the bundle also carries the hold (stall) input.
interface sha256_round_core_if;
    logic         start;
    logic         init_h;
    logic [31:0]  w;
    logic         ld_mreg;
    logic         upd_mreg;
    logic         busy;
    logic         done;
    logic [255:0] hash;
`ifdef SHA_HOLD_EN
    logic         hold;

    modport master (output start, init_h, w, hold,
                    input  ld_mreg, upd_mreg, busy, done, hash);
    modport slave  (input  start, init_h, w, hold,
                    output ld_mreg, upd_mreg, busy, done, hash);
`else
    modport master (output start, init_h, w,
                    input  ld_mreg, upd_mreg, busy, done, hash);
    modport slave  (input  start, init_h, w,
                    output ld_mreg, upd_mreg, busy, done, hash);
`endif
endinterface

// File: rtl/sha256_round_core.sv
// SHA-256 compression engine: 64 rounds per block fed by an external message schedule.
// Optional macro SHA_HOLD_EN adds a hold input that freezes the engine outside IDLE.
module sha256_round_core #(
    parameter int ROUNDS = 64
) (
    input  logic                clk,
    input  logic                rst_b,
    sha256_round_core_if.slave  bus
);
    localparam int TW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] t_reg;
    logic [31:0]   v_reg [8];
    logic [31:0]   h_reg [8];
    logic          init_reg;
    logic          done_reg;
    logic          stall;
    logic [31:0]   k_t, t1, t2;
    logic [255:0]  hash_words;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

`ifdef SHA_HOLD_EN
    assign stall = bus.hold && (state_reg != IDLE);
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!stall) begin
            case (state_reg)
                IDLE:    if (bus.start) state_next = LOAD;
                LOAD:    state_next = ROUND;
                ROUND:   if (t_reg == TW'(ROUNDS - 1)) state_next = FINAL;
                FINAL:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Strobes are gated by stall so the schedule datapath freezes in step with us.
    always_comb begin
        bus.ld_mreg  = 1'b0;
        bus.upd_mreg = 1'b0;
        bus.busy     = (state_reg != IDLE);
        if (!stall) begin
            case (state_reg)
                LOAD:    begin bus.ld_mreg = 1'b1; bus.upd_mreg = 1'b1; end
                ROUND:   bus.upd_mreg = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        k_t = K[t_reg];
        t1  = v_reg[7]
            + (rotr(v_reg[4], 6) ^ rotr(v_reg[4], 11) ^ rotr(v_reg[4], 25))
            + ((v_reg[4] & v_reg[5]) ^ (~v_reg[4] & v_reg[6]))
            + k_t + bus.w;
        t2  = (rotr(v_reg[0], 2) ^ rotr(v_reg[0], 13) ^ rotr(v_reg[0], 22))
            + ((v_reg[0] & v_reg[1]) ^ (v_reg[0] & v_reg[2]) ^ (v_reg[1] & v_reg[2]));
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            t_reg    <= '0;
            init_reg <= 1'b0;
            done_reg <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                v_reg[i] <= '0;
                h_reg[i] <= IV[i];
            end
        end else begin
            done_reg <= 1'b0;
            if (!stall) begin
                case (state_reg)
                    IDLE: if (bus.start) init_reg <= bus.init_h;
                    LOAD: begin
                        t_reg <= '0;
                        for (int i = 0; i < 8; i++) begin
                            if (init_reg) begin
                                v_reg[i] <= IV[i];
                                h_reg[i] <= IV[i];
                            end else begin
                                v_reg[i] <= h_reg[i];
                            end
                        end
                    end
                    ROUND: begin
                        v_reg[0] <= t1 + t2;
                        v_reg[1] <= v_reg[0];
                        v_reg[2] <= v_reg[1];
                        v_reg[3] <= v_reg[2];
                        v_reg[4] <= v_reg[3] + t1;
                        v_reg[5] <= v_reg[4];
                        v_reg[6] <= v_reg[5];
                        v_reg[7] <= v_reg[6];
                        t_reg    <= t_reg + 1'b1;
                    end
                    FINAL: begin
                        for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + v_reg[i];
                        done_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_hash
        assign hash_words[255 - 32*gi -: 32] = h_reg[gi];
    end

    assign bus.hash = hash_words;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_sha256_round_core.sv
// Bench for sha256_round_core: models the message-schedule block, runs known digests,
// chaining, ignored start, mid-run reset abort and (with SHA_HOLD_EN) the hold stall.
module tb_sha256_round_core;
    logic clk;
    logic rst_b;
    sha256_round_core_if bus ();

    sha256_round_core #(.ROUNDS(64)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] IV_HASH  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_HASH = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMP_HASH = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_HASH = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h0}}, 32'h00000018};

    // Message-schedule model: parallel load on ld_mreg, sliding W window on upd_mreg.
    logic [31:0] blk_cur [16];
    logic [31:0] sched [16];

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always @(posedge clk) begin
        if (bus.ld_mreg) begin
            for (int i = 0; i < 16; i++) sched[i] <= blk_cur[i];
        end else if (bus.upd_mreg) begin
            for (int i = 0; i < 15; i++) sched[i] <= sched[i+1];
            sched[15] <= (rr(sched[14], 17) ^ rr(sched[14], 19) ^ (sched[14] >> 10))
                       + sched[9]
                       + (rr(sched[1], 7) ^ rr(sched[1], 18) ^ (sched[1] >> 3))
                       + sched[0];
        end
    end
    assign bus.w = sched[0];

    typedef struct {
        logic [511:0] blk;
        bit           init_h;
        bit           has_exp;
        logic [255:0] exp;
        int           poke_at;
    } vec_t;

    typedef struct {
        logic [255:0] hash;
        bit           has_exp;
        int           lat;
    } sb_t;

    vec_t vecs [4];
    sb_t  sb_q [$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic run_block(input logic [511:0] blk, input bit ih, input bit has_exp,
                             input logic [255:0] exp, input int poke_at, input int hold_at);
        int  edges;
        bit  got;
        sb_t e;
        for (int i = 0; i < 16; i++) blk_cur[i] = blk[511 - 32*i -: 32];
        @(negedge clk);
        bus.start  = 1'b1;
        bus.init_h = ih;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.init_h = ~ih;
        sb_q.push_back('{hash: exp, has_exp: has_exp, lat: (hold_at > 0) ? 76 : 66});
        chk("load_strobes", 256'({bus.ld_mreg, bus.upd_mreg, bus.busy}), 256'(3'b111));
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.done) got = 1'b1;
            if (edges == 1)
                chk("round_strobes", 256'({bus.ld_mreg, bus.upd_mreg}), 256'(2'b01));
            if (poke_at > 0 && edges == poke_at) begin
                bus.start  = 1'b1;
                bus.init_h = 1'b1;
            end
            if (poke_at > 0 && edges == poke_at + 1) begin
                bus.start  = 1'b0;
                bus.init_h = 1'b0;
            end
`ifdef SHA_HOLD_EN
            if (hold_at > 0 && edges == hold_at) bus.hold = 1'b1;
            if (hold_at > 0 && edges == hold_at + 1)
                chk("hold_upd", 256'({bus.ld_mreg, bus.upd_mreg}), 256'(2'b00));
            if (hold_at > 0 && edges == hold_at + 10) bus.hold = 1'b0;
`endif
        end
        e = sb_q.pop_front();
        chk("done_latency", 256'(edges), 256'(e.lat));
        if (e.has_exp) chk("digest", bus.hash, e.hash);
        $display("block ih=%0d edges=%0d hash=%h", ih, edges, bus.hash);
        @(posedge clk);
        #1;
        chk("done_pulse_idle", 256'({bus.done, bus.busy}), 256'(2'b00));
    endtask

    task automatic quiet_check(input int n);
        int dones = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("stray_done", 256'(dones), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{blk: ABC_BLK, init_h: 1'b1, has_exp: 1'b1, exp: ABC_HASH, poke_at: 0};
        vecs[1] = '{blk: {32'h80000000, 480'h0}, init_h: 1'b1, has_exp: 1'b1, exp: EMP_HASH, poke_at: 0};
        vecs[2] = '{blk: {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000},
                    init_h: 1'b1, has_exp: 1'b0, exp: '0, poke_at: 0};
        vecs[3] = '{blk: {480'h0, 32'h000001c0}, init_h: 1'b0, has_exp: 1'b1, exp: TWO_HASH, poke_at: 10};

        rst_b      = 1'b0;
        bus.start  = 1'b0;
        bus.init_h = 1'b0;
`ifdef SHA_HOLD_EN
        bus.hold   = 1'b0;
`endif
        for (int i = 0; i < 16; i++) blk_cur[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_hash", bus.hash, IV_HASH);
        chk("reset_ctrl", 256'({bus.busy, bus.done, bus.ld_mreg, bus.upd_mreg}), 256'(4'b0000));
        rst_b = 1'b1;
        @(negedge clk);
        chk("idle_ctrl", 256'({bus.busy, bus.done, bus.ld_mreg, bus.upd_mreg}), 256'(4'b0000));

        for (int v = 0; v < 4; v++)
            run_block(vecs[v].blk, vecs[v].init_h, vecs[v].has_exp, vecs[v].exp, vecs[v].poke_at, 0);
        quiet_check(80);

        // Abort at round 30: reset must restore IV with no done pulse.
        for (int i = 0; i < 16; i++) blk_cur[i] = ABC_BLK[511 - 32*i -: 32];
        @(negedge clk);
        bus.start  = 1'b1;
        bus.init_h = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        chk("abort_hash", bus.hash, IV_HASH);
        chk("abort_ctrl", 256'({bus.busy, bus.done, bus.ld_mreg, bus.upd_mreg}), 256'(4'b0000));
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        quiet_check(70);
        run_block(ABC_BLK, 1'b1, 1'b1, ABC_HASH, 0, 0);

`ifdef SHA_HOLD_EN
        run_block(ABC_BLK, 1'b1, 1'b1, ABC_HASH, 0, 21);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
